// File: rtl/afifo_pop_stream.sv
//-----------------------------------------------------------------------------
// afifo_pop_stream
//
// Pop-side consumer for the AFIFO_36K_BLK asynchronous FIFO wrappers
// (af1024x36 / af2048x18 / af4096x9). Everything runs in the pop clock
// domain (clock1 is the same clock as the FIFO Pop_Clk).
//
// The FIFO returns DOUT one cycle after POP. This block issues POP, captures
// the returned word into a 2-entry prefetch buffer and presents the buffer
// head as a valid/ready stream.
//
// Timing from a POP issued in cycle N:
//    N   : POP = 1
//    N+1 : DOUT valid, r_inflight = 1, word written into the buffer at the
//          end of N+1
//    N+2 : m_valid = 1, m_data = word
//
// Ports:
//    clock1          in   pop-side clock
//    reset           in   synchronous active-high reset
//    Empty           in   FIFO empty flag; gates new POPs only
//    DOUT            in   FIFO read data, valid the cycle after POP
//    Underrun_Error  in   FIFO underrun indication
//    POP             out  FIFO pop request (combinational)
//    flush           in   discard buffered and in-flight data
//    m_data          out  stream data (buffer head, holds when m_valid = 0)
//    m_valid         out  stream valid
//    m_ready         in   stream ready
//    occupancy       out  number of words held in the buffer (0..2)
//    word_count      out  completed stream transfers, wraps
//    underrun_sticky out  set by Underrun_Error, cleared only by reset
//-----------------------------------------------------------------------------
module afifo_pop_stream #(
   parameter int DATA_WIDTH = 36,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clock1,
   input  logic                  reset,
   input  logic                  Empty,
   input  logic [DATA_WIDTH-1:0] DOUT,
   input  logic                  Underrun_Error,
   output logic                  POP,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [1:0]            occupancy,
   output logic [CNT_WIDTH-1:0]  word_count,
   output logic                  underrun_sticky
);

   //--------------------------------------------------------------------------
   // State
   //--------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_head;       // buffer entry 0, drives m_data
   logic [DATA_WIDTH-1:0] r_tail;       // buffer entry 1
   logic [1:0]            r_occ;        // words held (0..2)
   logic                  r_inflight;   // POP issued last cycle: DOUT valid now
   logic                  r_drop_next;  // discard the word currently arriving
   logic [CNT_WIDTH-1:0]  r_count;      // delivered-word counter
   logic                  r_sticky;     // latched underrun

   //--------------------------------------------------------------------------
   // Combinational control
   //--------------------------------------------------------------------------
   logic                  w_valid;
   logic                  w_fire;
   logic                  w_capture;
   logic [2:0]            w_level;
   logic                  w_pop;

   logic [DATA_WIDTH-1:0] w_head_next;
   logic [DATA_WIDTH-1:0] w_tail_next;
   logic [1:0]            w_occ_next;
   logic                  w_drop_next_next;

   assign w_valid   = (r_occ != 2'd0);
   assign w_fire    = w_valid & m_ready;

   // A returning word is written unless it belongs to a pop that a flush
   // has already cancelled.
   assign w_capture = r_inflight & ~r_drop_next;

   // Words that will occupy the buffer once everything already requested has
   // landed and this cycle's transfer has left. Issuing a POP only while this
   // is below 2 means a capture can never hit a full buffer, while still
   // allowing one POP every cycle when the stream is draining.
   // fire implies r_occ >= 1, so the subtraction cannot underflow.
   assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_fire};

   assign w_pop     = ~Empty & ~flush & ~reset & (w_level < 3'd2);

   //--------------------------------------------------------------------------
   // Buffer next state
   //
   // The pair behaves as a tiny FIFO: the head is always the oldest word.
   // When a transfer and a capture coincide, the head leaves and the new
   // word takes the freed position, so occupancy is unchanged; with one word
   // held this is a zero-bubble pass-through.
   // Data registers are never cleared on drain or flush so m_data holds its
   // last value while m_valid is low.
   //--------------------------------------------------------------------------
   always_comb begin
      w_head_next = r_head;
      w_tail_next = r_tail;
      w_occ_next  = r_occ;

      if (flush) begin
         w_occ_next = 2'd0;
      end else begin
         case ({w_capture, w_fire})
            2'b10: begin
               // capture only
               if (r_occ == 2'd0) begin
                  w_head_next = DOUT;
                  w_occ_next  = 2'd1;
               end else begin
                  w_tail_next = DOUT;
                  w_occ_next  = 2'd2;
               end
            end
            2'b01: begin
               // transfer only; a second entry moves up to the head
               if (r_occ == 2'd2) begin
                  w_head_next = r_tail;
               end
               w_occ_next = r_occ - 2'd1;
            end
            2'b11: begin
               // transfer and capture together
               if (r_occ == 2'd1) begin
                  w_head_next = DOUT;
               end else begin
                  w_head_next = r_tail;
                  w_tail_next = DOUT;
               end
            end
            default: begin
               // nothing moves
            end
         endcase
      end
   end

   // A flush on an edge where a word is in flight marks that word for
   // discard. POP is forced low during flush, so nothing new is requested
   // in the flush cycle; the mark therefore only ever covers a word already
   // requested and it self-clears on the following edge.
   assign w_drop_next_next = flush & r_inflight;

   //--------------------------------------------------------------------------
   // Registers
   //--------------------------------------------------------------------------
   always_ff @(posedge clock1) begin
      if (reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_occ       <= 2'd0;
         r_inflight  <= 1'b0;
         r_drop_next <= 1'b0;
         r_count     <= '0;
         r_sticky    <= 1'b0;
      end else begin
         r_head      <= w_head_next;
         r_tail      <= w_tail_next;
         r_occ       <= w_occ_next;
         r_inflight  <= w_pop;
         r_drop_next <= w_drop_next_next;
         // A transfer in the flush cycle still completes and is counted.
         if (w_fire) begin
            r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (Underrun_Error) begin
            r_sticky <= 1'b1;
         end
      end
   end

   //--------------------------------------------------------------------------
   // Outputs
   //--------------------------------------------------------------------------
   assign POP             = w_pop;
   assign m_data          = r_head;
   assign m_valid         = w_valid;
   assign occupancy       = r_occ;
   assign word_count      = r_count;
   assign underrun_sticky = r_sticky;

endmodule

// File: tb/tb_afifo_pop_stream.sv
//-----------------------------------------------------------------------------
// tb_afifo_pop_stream
//
// Directed bench for afifo_pop_stream. A behavioural FIFO returns DOUT one
// cycle after POP. Inputs are driven and outputs sampled on the falling edge.
//-----------------------------------------------------------------------------
module tb_afifo_pop_stream;

   localparam int DW = 36;
   localparam int CW = 16;

   logic          clk;
   logic          reset;
   logic          Empty;
   logic [DW-1:0] DOUT;
   logic          Underrun_Error;
   logic          POP;
   logic          flush;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [1:0]    occupancy;
   logic [CW-1:0] word_count;
   logic          underrun_sticky;

   int total = 0;
   int bad   = 0;

   // behavioural source FIFO
   logic [DW-1:0] mem [0:2047];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          fifo_clr;

   // monitors
   int pop_count       = 0;
   int pop_when_empty  = 0;
   int occ_over        = 0;

   afifo_pop_stream #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clock1          (clk),
      .reset           (reset),
      .Empty           (Empty),
      .DOUT            (DOUT),
      .Underrun_Error  (Underrun_Error),
      .POP             (POP),
      .flush           (flush),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .occupancy       (occupancy),
      .word_count      (word_count),
      .underrun_sticky (underrun_sticky)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign Empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr <= 0;
         DOUT   <= '0;
      end else if (POP && !Empty) begin
         DOUT   <= mem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   always @(posedge clk) begin
      if (POP) pop_count <= pop_count + 1;
      if (POP && Empty) pop_when_empty <= pop_when_empty + 1;
      if (occupancy > 2'd2) occ_over <= occ_over + 1;
   end

   task automatic push(input logic [DW-1:0] v);
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      fifo_clr = 1'b1;
      wr_ptr = 0;
      m_ready = 1'b0;
      flush = 1'b0;
      Underrun_Error = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      fifo_clr = 1'b0;
   endtask

   //--------------------------------------------------------------------------
   task automatic test_reset();
      logic [CW+3:0] got;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         got = {POP, m_valid, occupancy, word_count};
         total++;
         if (got !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc%0d: got POP/valid/occ/count=%0h expected 0", i, got);
         end
         @(negedge clk);
      end
      total++;
      if (underrun_sticky !== 1'b0) begin
         bad++;
         $display("FAIL reset_sticky: got %0b expected 0", underrun_sticky);
      end
      $display("test_reset done");
   endtask

   //--------------------------------------------------------------------------
   task automatic test_stream8();
      logic exp_pop;
      logic exp_valid;
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(DW'(i + 1));
      #1;
      for (int k = 0; k < 12; k++) begin
         exp_pop   = (k < 8);
         exp_valid = (k >= 2) && (k < 10);
         total++;
         if (POP !== exp_pop) begin
            bad++;
            $display("FAIL stream8_pop cyc%0d: got %0b expected %0b", k, POP, exp_pop);
         end
         total++;
         if (m_valid !== exp_valid) begin
            bad++;
            $display("FAIL stream8_valid cyc%0d: got %0b expected %0b", k, m_valid, exp_valid);
         end
         if (exp_valid) begin
            total++;
            if (m_data !== DW'(k - 1)) begin
               bad++;
               $display("FAIL stream8_data cyc%0d: got %0h expected %0h", k, m_data, k - 1);
            end
         end
         @(negedge clk);
      end
      m_ready = 1'b0;
      total++;
      if (word_count !== 16'd8) begin
         bad++;
         $display("FAIL stream8_count: got %0d expected 8", word_count);
      end
      $display("test_stream8 done");
   endtask

   //--------------------------------------------------------------------------
   task automatic test_backpressure();
      int base;
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
      w0 = 36'hA_0000_0000;
      w1 = 36'hA_0000_0001;
      do_reset();
      base = pop_count;
      for (int i = 0; i < 5; i++) push(36'hA_0000_0000 + DW'(i));
      repeat (8) @(negedge clk);
      total++;
      if (pop_count - base !== 2) begin
         bad++;
         $display("FAIL bp_pops_stalled: got %0d expected 2", pop_count - base);
      end
      total++;
      if (occupancy !== 2'd2 || m_valid !== 1'b1) begin
         bad++;
         $display("FAIL bp_full: got occ=%0d valid=%0b expected occ=2 valid=1", occupancy, m_valid);
      end
      total++;
      if (m_data !== w0) begin
         bad++;
         $display("FAIL bp_head: got %0h expected %0h", m_data, w0);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      total++;
      if (word_count !== 16'd1 || occupancy !== 2'd1 || m_data !== w1) begin
         bad++;
         $display("FAIL bp_after_fire: got count=%0d occ=%0d data=%0h expected 1/1/%0h",
                  word_count, occupancy, m_data, w1);
      end
      @(negedge clk);
      total++;
      if (occupancy !== 2'd2 || pop_count - base !== 3) begin
         bad++;
         $display("FAIL bp_refill: got occ=%0d pops=%0d expected occ=2 pops=3",
                  occupancy, pop_count - base);
      end
      repeat (4) @(negedge clk);
      total++;
      if (pop_count - base !== 3 || m_data !== w1 || word_count !== 16'd1) begin
         bad++;
         $display("FAIL bp_hold: got pops=%0d data=%0h count=%0d expected 3/%0h/1",
                  pop_count - base, m_data, word_count, w1);
      end
      $display("test_backpressure done");
   endtask

   //--------------------------------------------------------------------------
   task automatic test_random();
      int base_pop;
      int base_pe;
      int base_oo;
      int exp;
      int errs;
      int cyc;
      do_reset();
      base_pop = pop_count;
      base_pe  = pop_when_empty;
      base_oo  = occ_over;
      for (int i = 0; i < 1000; i++) push(DW'(i));
      exp = 0;
      errs = 0;
      cyc = 0;
      while (exp < 1000 && cyc < 6000) begin
         m_ready = 1'($urandom_range(0, 1));
         if (m_valid && m_ready) begin
            if (m_data !== DW'(exp)) errs++;
            exp++;
         end
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      total++;
      if (exp !== 1000) begin
         bad++;
         $display("FAIL rand_delivered: got %0d expected 1000 within bound", exp);
      end
      total++;
      if (errs !== 0) begin
         bad++;
         $display("FAIL rand_order: got %0d out-of-order words expected 0", errs);
      end
      total++;
      if (word_count !== 16'd1000) begin
         bad++;
         $display("FAIL rand_count: got %0d expected 1000", word_count);
      end
      total++;
      if (pop_count - base_pop !== 1000) begin
         bad++;
         $display("FAIL rand_pops: got %0d expected 1000", pop_count - base_pop);
      end
      total++;
      if (pop_when_empty - base_pe !== 0 || occ_over - base_oo !== 0) begin
         bad++;
         $display("FAIL rand_safety: got pop_when_empty=%0d occ_over=%0d expected 0/0",
                  pop_when_empty - base_pe, occ_over - base_oo);
      end
      $display("test_random done: %0d words in %0d cycles", exp, cyc);
   endtask

   //--------------------------------------------------------------------------
   task automatic test_flush();
      logic [DW-1:0] wa;
      logic [DW-1:0] wb;
      logic [DW-1:0] wc;
      logic [DW-1:0] wd;
      wa = 36'h1_1111_1111;
      wb = 36'h2_2222_2222;
      wc = 36'h3_3333_3333;
      wd = 36'h4_4444_4444;
      do_reset();
      push(wa);
      repeat (2) @(negedge clk);
      total++;
      if (occupancy !== 2'd1) begin
         bad++;
         $display("FAIL flush_setup_occ: got %0d expected 1", occupancy);
      end
      push(wb);
      push(wc);
      push(wd);
      #1;
      total++;
      if (POP !== 1'b1) begin
         bad++;
         $display("FAIL flush_setup_pop: got %0b expected 1", POP);
      end
      @(negedge clk);
      // wb is in flight, wa held
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (occupancy !== 2'd0 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_clear: got occ=%0d valid=%0b expected 0/0", occupancy, m_valid);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (m_valid) break;
         @(negedge clk);
      end
      total++;
      if (m_valid !== 1'b1 || m_data !== wc) begin
         bad++;
         $display("FAIL flush_next_word: got valid=%0b data=%0h expected 1/%0h", m_valid, m_data, wc);
      end
      @(negedge clk);
      total++;
      if (word_count !== 16'd1 || m_data !== wd || m_valid !== 1'b1) begin
         bad++;
         $display("FAIL flush_following: got count=%0d data=%0h expected 1/%0h",
                  word_count, m_data, wd);
      end
      // flush while a transfer completes: POP forced low, transfer counted
      push(36'h5_5555_5555);
      flush = 1'b1;
      #1;
      total++;
      if (POP !== 1'b0) begin
         bad++;
         $display("FAIL flush_forces_pop: got %0b expected 0", POP);
      end
      @(negedge clk);
      flush = 1'b0;
      m_ready = 1'b0;
      #1;
      total++;
      if (word_count !== 16'd2 || occupancy !== 2'd0 || POP !== 1'b1) begin
         bad++;
         $display("FAIL flush_fire_counted: got count=%0d occ=%0d pop=%0b expected 2/0/1",
                  word_count, occupancy, POP);
      end
      $display("test_flush done");
   endtask

   //--------------------------------------------------------------------------
   task automatic test_underrun();
      do_reset();
      Underrun_Error = 1'b1;
      @(negedge clk);
      Underrun_Error = 1'b0;
      total++;
      if (underrun_sticky !== 1'b1) begin
         bad++;
         $display("FAIL underrun_set: got %0b expected 1", underrun_sticky);
      end
      for (int i = 0; i < 100; i++) push(36'h6_0000_0000 + DW'(i));
      m_ready = 1'b1;
      repeat (110) @(negedge clk);
      m_ready = 1'b0;
      total++;
      if (underrun_sticky !== 1'b1 || word_count !== 16'd100) begin
         bad++;
         $display("FAIL underrun_hold: got sticky=%0b count=%0d expected 1/100",
                  underrun_sticky, word_count);
      end
      do_reset();
      total++;
      if (underrun_sticky !== 1'b0) begin
         bad++;
         $display("FAIL underrun_reset: got %0b expected 0", underrun_sticky);
      end
      $display("test_underrun done");
   endtask

   //--------------------------------------------------------------------------
   initial begin
      reset = 1'b1;
      fifo_clr = 1'b1;
      m_ready = 1'b0;
      flush = 1'b0;
      Underrun_Error = 1'b0;
      test_reset();
      test_stream8();
      test_backpressure();
      test_random();
      test_flush();
      test_underrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
